// File: rtl/bsg_imul_shared_sched.sv
// Round-robin scheduler sharing one iterative multiplier among els_p requesters.
// One operation is in flight at a time; its result is held until the owner consumes it.
module bsg_imul_shared_sched #(
  parameter int width_p = 32,
  parameter int els_p = 4,
  localparam int lg_els_lp = (els_p > 1) ? $clog2(els_p) : 1
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [els_p-1:0]         v_i,
  output logic [els_p-1:0]         ready_o,
  input  logic [els_p*width_p-1:0] opA_i,
  input  logic [els_p*width_p-1:0] opB_i,
  input  logic [els_p-1:0]         signed_opA_i,
  input  logic [els_p-1:0]         signed_opB_i,
  input  logic [els_p-1:0]         gets_high_part_i,
  output logic [els_p-1:0]         v_o,
  output logic [width_p-1:0]       result_o,
  input  logic [els_p-1:0]         yumi_i,
  output logic [lg_els_lp-1:0]     owner_o,
  output logic                     mul_v_o,
  input  logic                     mul_ready_i,
  output logic [width_p-1:0]       mul_opA_o,
  output logic [width_p-1:0]       mul_opB_o,
  output logic                     mul_signed_opA_o,
  output logic                     mul_signed_opB_o,
  output logic                     mul_gets_high_part_o,
  input  logic                     mul_v_i,
  input  logic [width_p-1:0]       mul_result_i,
  output logic                     mul_yumi_o
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RETURN} state_e;

  state_e               state_q;
  logic [lg_els_lp-1:0] p_q;
  logic [lg_els_lp-1:0] owner_q;
  logic [width_p-1:0]   opA_q;
  logic [width_p-1:0]   opB_q;
  logic                 sa_q;
  logic                 sb_q;
  logic                 hi_q;
  logic [width_p-1:0]   result_q;
  logic                 mul_v_q;

  logic [lg_els_lp:0]   scan_idx;
  logic [lg_els_lp-1:0] winner;
  logic                 any_v;
  logic                 grant;
  logic [width_p-1:0]   win_opA;
  logic [width_p-1:0]   win_opB;
  logic                 win_sa;
  logic                 win_sb;
  logic                 win_hi;
  logic                 owner_yumi;
  logic [lg_els_lp-1:0] p_next;

  // Scan p, p+1, ... modulo els_p; the first active requester wins.
  always_comb begin
    winner   = '0;
    any_v    = 1'b0;
    scan_idx = '0;
    for (int i = 0; i < els_p; i++) begin
      scan_idx = {1'b0, p_q} + (lg_els_lp+1)'(i);
      if (scan_idx >= (lg_els_lp+1)'(els_p))
        scan_idx = scan_idx - (lg_els_lp+1)'(els_p);
      if (!any_v && v_i[scan_idx[lg_els_lp-1:0]]) begin
        any_v  = 1'b1;
        winner = scan_idx[lg_els_lp-1:0];
      end
    end
  end

  always_comb begin
    win_opA = '0;
    win_opB = '0;
    win_sa  = 1'b0;
    win_sb  = 1'b0;
    win_hi  = 1'b0;
    for (int k = 0; k < els_p; k++) begin
      if (winner == lg_els_lp'(k)) begin
        win_opA = opA_i[k*width_p +: width_p];
        win_opB = opB_i[k*width_p +: width_p];
        win_sa  = signed_opA_i[k];
        win_sb  = signed_opB_i[k];
        win_hi  = gets_high_part_i[k];
      end
    end
  end

  assign grant      = (state_q == S_IDLE) && mul_ready_i && any_v;
  assign owner_yumi = (state_q == S_RETURN) && yumi_i[owner_q];
  assign p_next     = (owner_q == lg_els_lp'(els_p-1)) ? '0 : owner_q + 1'b1;

  always_comb begin
    ready_o = '0;
    v_o     = '0;
    if (grant)
      ready_o[winner] = 1'b1;
    if (state_q == S_RETURN)
      v_o[owner_q] = 1'b1;
  end

  assign mul_yumi_o = (state_q == S_WAIT) && mul_v_i;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= S_IDLE;
      p_q      <= '0;
      owner_q  <= '0;
      opA_q    <= '0;
      opB_q    <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      hi_q     <= 1'b0;
      result_q <= '0;
      mul_v_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (grant) begin
          opA_q   <= win_opA;
          opB_q   <= win_opB;
          sa_q    <= win_sa;
          sb_q    <= win_sb;
          hi_q    <= win_hi;
          owner_q <= winner;
          mul_v_q <= 1'b1;
          state_q <= S_ISSUE;
        end
        S_ISSUE: if (mul_ready_i) begin
          mul_v_q <= 1'b0;
          state_q <= S_WAIT;
        end
        S_WAIT: if (mul_v_i) begin
          result_q <= mul_result_i;
          state_q  <= S_RETURN;
        end
        S_RETURN: if (owner_yumi) begin
          p_q     <= p_next;
          owner_q <= '0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign result_o             = result_q;
  assign owner_o              = owner_q;
  assign mul_v_o              = mul_v_q;
  assign mul_opA_o            = opA_q;
  assign mul_opB_o            = opB_q;
  assign mul_signed_opA_o     = sa_q;
  assign mul_signed_opB_o     = sb_q;
  assign mul_gets_high_part_o = hi_q;

endmodule

// File: tb/tb_bsg_imul_shared_sched.sv
// Directed bench for bsg_imul_shared_sched with a behavioural iterative multiplier
// (issue-to-valid latency of 4 cycles).
module tb_bsg_imul_shared_sched;
  localparam int W = 32;
  localparam int N = 4;

  logic           clk;
  logic           reset;
  logic [N-1:0]   v;
  logic [N-1:0]   ready;
  logic [N*W-1:0] opA;
  logic [N*W-1:0] opB;
  logic [N-1:0]   sa;
  logic [N-1:0]   sb;
  logic [N-1:0]   hi;
  logic [N-1:0]   vo;
  logic [W-1:0]   result;
  logic [N-1:0]   yumi;
  logic [1:0]     owner;
  logic           mul_vo;
  logic           mul_ready;
  logic [W-1:0]   mul_opA;
  logic [W-1:0]   mul_opB;
  logic           mul_sa;
  logic           mul_sb;
  logic           mul_hi;
  logic           mul_vi;
  logic [W-1:0]   mul_result;
  logic           mul_yumi;

  int vectors;
  int miscompares;

  bsg_imul_shared_sched #(.width_p(W), .els_p(N)) dut (
    .clk_i(clk), .reset_i(reset),
    .v_i(v), .ready_o(ready), .opA_i(opA), .opB_i(opB),
    .signed_opA_i(sa), .signed_opB_i(sb), .gets_high_part_i(hi),
    .v_o(vo), .result_o(result), .yumi_i(yumi), .owner_o(owner),
    .mul_v_o(mul_vo), .mul_ready_i(mul_ready),
    .mul_opA_o(mul_opA), .mul_opB_o(mul_opB),
    .mul_signed_opA_o(mul_sa), .mul_signed_opB_o(mul_sb),
    .mul_gets_high_part_o(mul_hi),
    .mul_v_i(mul_vi), .mul_result_i(mul_result), .mul_yumi_o(mul_yumi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] mul_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic s_a, input logic s_b, input logic h);
    logic signed [2*W+1:0] ea;
    logic signed [2*W+1:0] eb;
    logic signed [2*W+1:0] pr;
    ea = s_a ? {{(W+2){a[W-1]}}, a} : {{(W+2){1'b0}}, a};
    eb = s_b ? {{(W+2){b[W-1]}}, b} : {{(W+2){1'b0}}, b};
    pr = ea * eb;
    return h ? pr[2*W-1:W] : pr[W-1:0];
  endfunction

  logic       mbusy;
  logic       mdone;
  logic [2:0] mcnt;
  logic [W-1:0] mres;
  assign mul_ready  = !mbusy && !mdone;
  assign mul_vi     = mdone;
  assign mul_result = mres;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mbusy <= 1'b0;
      mdone <= 1'b0;
      mcnt  <= '0;
      mres  <= '0;
    end else if (mbusy) begin
      if (mcnt == 0) begin
        mbusy <= 1'b0;
        mdone <= 1'b1;
      end else begin
        mcnt <= mcnt - 1'b1;
      end
    end else if (mdone) begin
      if (mul_yumi) mdone <= 1'b0;
    end else if (mul_vo) begin
      mbusy <= 1'b1;
      mcnt  <= 3'd2;
      mres  <= mul_model(mul_opA, mul_opB, mul_sa, mul_sb, mul_hi);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic req(input int k, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic s_a, input logic s_b, input logic h);
    opA[k*W +: W] = a;
    opB[k*W +: W] = b;
    sa[k] = s_a;
    sb[k] = s_b;
    hi[k] = h;
    v[k]  = 1'b1;
  endtask

  // Called just after a falling edge; returns on the falling edge after the grant.
  task automatic wait_grant(input int k, input string tag, output int n);
    n = 0;
    #1;
    while (ready == '0 && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk({tag, "_ready"}, 64'(ready), 64'd1 << k);
    @(negedge clk);
    v[k] = 1'b0;
  endtask

  task automatic wait_resp(input int k, input logic [W-1:0] exp, input string tag,
                           input int hold, output int n);
    n = 0;
    #1;
    while (vo == '0 && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk({tag, "_v_o"}, 64'(vo), 64'd1 << k);
    chk({tag, "_result"}, 64'(result), 64'(exp));
    chk({tag, "_owner"}, 64'(owner), 64'(k));
    for (int c = 0; c < hold; c++) begin
      @(negedge clk);
      #1;
      chk({tag, "_hold_v_o"}, 64'(vo), 64'd1 << k);
      chk({tag, "_hold_result"}, 64'(result), 64'(exp));
      chk({tag, "_hold_ready"}, 64'(ready), 64'd0);
      chk({tag, "_hold_mul_v"}, 64'(mul_vo), 64'd0);
    end
    yumi = '1;  // non-owner bits must be ignored
    @(negedge clk);
    yumi = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int n;
    int seen;
    vectors = 0;
    miscompares = 0;
    reset = 1'b1;
    v = '0; yumi = '0; opA = '0; opB = '0; sa = '0; sb = '0; hi = '0;
    #2;
    chk("rst_ready", 64'(ready), 64'd0);
    chk("rst_v_o", 64'(vo), 64'd0);
    chk("rst_mul_v", 64'(mul_vo), 64'd0);
    chk("rst_mul_yumi", 64'(mul_yumi), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_owner", 64'(owner), 64'd0);
    chk("rst_ops", {mul_opA, mul_opB}, 64'd0);
    chk("rst_modes", 64'({mul_sa, mul_sb, mul_hi}), 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Single requester, signed low half
    @(negedge clk);
    req(0, 32'hFFFF_FFFF, 32'h0000_0011, 1'b1, 1'b1, 1'b0);
    wait_grant(0, "t1", n);
    #1;
    chk("t1_issue_mul_v", 64'(mul_vo), 64'd1);
    chk("t1_issue_ops", {mul_opA, mul_opB}, 64'hFFFF_FFFF_0000_0011);
    chk("t1_issue_modes", 64'({mul_sa, mul_sb, mul_hi}), 64'b110);
    chk("t1_issue_ready", 64'(ready), 64'd0);
    wait_resp(0, 32'hFFFF_FFEF, "t1", 0, n);
    chk("t1_latency", 64'(n), 64'd5);

    // Signed and unsigned high half
    req(0, 32'h8000_8000, 32'h0000_0011, 1'b1, 1'b1, 1'b1);
    wait_grant(0, "t2s", n);
    wait_resp(0, 32'hFFFF_FFF7, "t2s", 0, n);
    req(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1);
    wait_grant(0, "t2u", n);
    wait_resp(0, 32'hFFFF_FFFE, "t2u", 0, n);

    // Fairness after reset: all four at once
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < N; k++) req(k, W'(k + 1), 32'd3, 1'b0, 1'b0, 1'b0);
    wait_grant(0, "fair0", n);
    wait_resp(0, 32'd3, "fair0", 0, n);
    wait_grant(1, "fair1", n);
    chk("fair1_b2b", 64'(n), 64'd0);
    wait_resp(1, 32'd6, "fair1", 0, n);
    wait_grant(2, "fair2", n);
    wait_resp(2, 32'd9, "fair2", 0, n);
    wait_grant(3, "fair3", n);
    wait_resp(3, 32'd12, "fair3", 0, n);

    // Rotation: after requester 1 alone, p=2 so requester 0 beats 1
    req(1, 32'd5, 32'd7, 1'b0, 1'b0, 1'b0);
    wait_grant(1, "rot_solo", n);
    wait_resp(1, 32'd35, "rot_solo", 0, n);
    req(0, 32'd2, 32'd2, 1'b0, 1'b0, 1'b0);
    req(1, 32'd3, 32'd3, 1'b0, 1'b0, 1'b0);
    wait_grant(0, "rot_first", n);
    wait_resp(0, 32'd4, "rot_first", 0, n);
    wait_grant(1, "rot_second", n);
    wait_resp(1, 32'd9, "rot_second", 0, n);

    // Back-pressure with a late request from requester 2
    req(3, 32'h10, 32'h10, 1'b0, 1'b0, 1'b0);
    wait_grant(3, "bp3", n);
    req(2, 32'd7, 32'd9, 1'b0, 1'b0, 1'b0);
    wait_resp(3, 32'h100, "bp3", 10, n);
    wait_grant(2, "bp2", n);
    chk("bp2_next_cycle", 64'(n), 64'd0);
    wait_resp(2, 32'h3F, "bp2", 0, n);

    // Asynchronous reset while in WAIT
    req(1, 32'h1234, 32'd2, 1'b0, 1'b0, 1'b0);
    wait_grant(1, "rw", n);
    @(negedge clk);
    #1;
    chk("rw_wait_mul_v", 64'(mul_vo), 64'd0);
    #2;
    reset = 1'b1;
    #1;
    chk("rw_v_o", 64'(vo), 64'd0);
    chk("rw_mul_v", 64'(mul_vo), 64'd0);
    chk("rw_mul_yumi", 64'(mul_yumi), 64'd0);
    chk("rw_result", 64'(result), 64'd0);
    chk("rw_owner", 64'(owner), 64'd0);
    chk("rw_ops", {mul_opA, mul_opB}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      #1;
      if (vo != '0) seen++;
    end
    chk("rw_no_stale_v_o", 64'(seen), 64'd0);
    @(negedge clk);
    req(0, 32'd4, 32'd4, 1'b0, 1'b0, 1'b0);
    req(3, 32'hFFFF_FFFF, 32'd2, 1'b1, 1'b0, 1'b0);
    wait_grant(0, "rw_p0", n);
    wait_resp(0, 32'h10, "rw_p0", 0, n);
    wait_grant(3, "rw_r3", n);
    wait_resp(3, 32'hFFFF_FFFE, "rw_r3", 0, n);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
